// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: sends one BITS-wide word MSB first on a start strobe,
// captures MISO on SCLK rising edges and pulses o_done with the received word.
module spi_master_ctrl #(
  parameter int BITS    = 5,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_tx_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_rx_data,
  output logic            o_cs,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso
);

  localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(BITS);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [BITS-1:0] tx_sr, tx_n, rx_sr, rx_n, rxd_n;
  logic            cs_n, sclk_n, mosi_n, busy_n, done_n;
  logic            half_end, gap_end;

  assign half_end = (cnt == CW'(CLK_DIV - 1));
  assign gap_end  = (cnt == CW'(CS_GAP - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    tx_n    = tx_sr;
    rx_n    = rx_sr;
    rxd_n   = o_rx_data;
    cs_n    = o_cs;
    sclk_n  = o_sclk;
    mosi_n  = o_mosi;
    busy_n  = o_busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          tx_n    = i_tx_data;
          mosi_n  = i_tx_data[BITS-1];
          cs_n    = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = '0;
          bit_n   = '0;
          rx_n    = '0;
          state_n = SETUP;
        end
      end
      SETUP, LOW: begin
        if (half_end) begin
          // rising edge: MISO is captured in the same cycle SCLK goes high
          cnt_n   = '0;
          sclk_n  = 1'b1;
          rx_n    = {rx_sr[BITS-2:0], i_miso};
          state_n = HIGH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (half_end) begin
          cnt_n  = '0;
          sclk_n = 1'b0;
          tx_n   = {tx_sr[BITS-2:0], 1'b0};
          mosi_n = tx_sr[BITS-2];
          if (bit_cnt == BW'(BITS - 1)) begin
            bit_n   = '0;
            state_n = FINISH;
          end else begin
            bit_n   = bit_cnt + BW'(1);
            state_n = LOW;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FINISH: begin
        if (half_end) begin
          cnt_n   = '0;
          cs_n    = 1'b1;
          mosi_n  = 1'b0;
          rxd_n   = rx_sr;
          done_n  = 1'b1;
          state_n = GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      o_rx_data <= '0;
      o_cs      <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      tx_sr     <= tx_n;
      rx_sr     <= rx_n;
      o_rx_data <= rxd_n;
      o_cs      <= cs_n;
      o_sclk    <= sclk_n;
      o_mosi    <= mosi_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: expected words go into a scoreboard queue,
// a negedge monitor pops on o_done and also watches SCLK/CS/MOSI pin rules.
module tb_spi_master_ctrl;
  localparam int BITS = 5, CLK_DIV = 2, CS_GAP = 2;

  logic clk = 1'b0;
  logic rst, start, miso, busy, done, cs, sclk, mosi;
  logic [BITS-1:0] tx, rx;
  logic loop = 1'b0, miso_val = 1'b0;

  assign miso = loop ? mosi : miso_val;
  always #5 clk = ~clk;

  spi_master_ctrl #(.BITS(BITS), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx),
    .o_busy(busy), .o_done(done), .o_rx_data(rx),
    .o_cs(cs), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  int e0 = 0;
  logic sclk_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0, busy_q = 1'b0;
  int win_rises = 0, high_run = 0;
  bit abort = 1'b0;
  int rise_log[$], done_log[$], bfall_log[$];
  logic [BITS-1:0] exp_q[$];

  always @(negedge clk) begin
    int n;
    logic [BITS-1:0] e;
    n = cyc - e0 + 1;
    if (sclk === 1'b1 && sclk_q === 1'b0) begin
      rise_log.push_back(n);
      win_rises++;
      check("sclk_rise_cs_low", cs, 0);
      check("mosi_stable_at_rise", mosi, mosi_q);
    end
    if (cs === 1'b0 && cs_q === 1'b1) begin
      check("cs_gap_len_ok", high_run >= CS_GAP, 1);
      win_rises = 0;
    end
    if (cs === 1'b1 && cs_q === 1'b0 && !abort)
      check("rises_per_window", win_rises, BITS);
    high_run = (cs === 1'b1) ? high_run + 1 : 0;
    if (busy_q === 1'b1 && busy === 1'b0) bfall_log.push_back(n);
    if (done === 1'b1) begin
      done_log.push_back(n);
      if (exp_q.size() == 0) check("done_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("rx_data", rx, e);
      end
    end
    sclk_q = sclk; cs_q = cs; mosi_q = mosi; busy_q = busy;
  end

  bit mosi_hi;

  // called at a negedge; returns at the negedge right after the accepting edge
  task automatic begin_xfer(input logic [BITS-1:0] d);
    e0 = cyc + 1;
    rise_log.delete(); done_log.delete(); bfall_log.delete();
    start = 1'b1; tx = d;
    @(negedge clk);
    start = 1'b0; tx = ~d;
    check("e0p1_cs_low", cs, 0);
    check("e0p1_busy", busy, 1);
    check("e0p1_mosi_msb", mosi, d[BITS-1]);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    mosi_hi = 1'b0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      if (mosi === 1'b1) mosi_hi = 1'b1;
      k++;
    end
    check("busy_timeout_ok", k < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; tx = 5'b11111;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_cs", cs, 1);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx", rx, 0);
    end
    check("rst_no_sclk", rise_log.size(), 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // loopback with full timing check
    loop = 1'b1;
    exp_q.push_back(5'b10110);
    begin_xfer(5'b10110);
    wait_idle();
    check("rise_count", rise_log.size(), BITS);
    for (int k = 0; k < rise_log.size() && k < BITS; k++)
      check("rise_time", rise_log[k], 3 + 4 * k);
    check("done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("done_time", done_log[0], 23);
    check("busy_fall_count", bfall_log.size(), 1);
    if (bfall_log.size() > 0) check("busy_fall_time", bfall_log[0], 25);
    check("rx_held", rx, 5'b10110);

    // constant MISO
    loop = 1'b0; miso_val = 1'b1;
    exp_q.push_back(5'b11111);
    begin_xfer(5'b00000);
    wait_idle();
    check("mosi_stays_low", mosi_hi, 0);
    miso_val = 1'b0;
    exp_q.push_back(5'b00000);
    begin_xfer(5'b00000);
    wait_idle();

    // busy lockout: starts at E0+5 and E0+24 ignored, E0+25 accepted
    loop = 1'b1;
    exp_q.push_back(5'b11001);
    begin_xfer(5'b11001);
    while (cyc != e0 + 4) @(negedge clk);
    start = 1'b1; tx = 5'b00110;
    @(negedge clk);
    start = 1'b0; tx = 5'b10101;
    while (cyc != e0 + 23) @(negedge clk);
    start = 1'b1; tx = 5'b00110;
    @(negedge clk);
    tx = 5'b01110;
    exp_q.push_back(5'b01110);
    @(negedge clk);
    start = 1'b0; tx = 5'b00000;
    wait_idle();
    check("lockout_done_count", done_log.size(), 2);
    if (done_log.size() > 1) begin
      check("lockout_done0_time", done_log[0], 23);
      check("lockout_done1_time", done_log[1], 48);
    end

    // reset abort at E0+9
    abort = 1'b1;
    begin_xfer(5'b10110);
    while (cyc != e0 + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_rx_cleared", rx, 0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_log.size(), 0);
    abort = 1'b0;
    repeat (2) @(negedge clk);

    exp_q.push_back(5'b01001);
    begin_xfer(5'b01001);
    wait_idle();
    check("post_abort_rx", rx, 5'b01001);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 master controller that sequences one full-duplex word transfer against the `spi_exe_unit_*` slave datapath. It accepts a parallel word on a single-cycle start strobe and drives `o_cs`/`o_sclk`/`o_mosi` from the system clock. It shifts MSB first, captures `i_miso` into a parallel result and signals completion with a one-cycle done pulse. It sits between the test/host logic and the SPI pins, so the slave exe units can be exercised without a hand-written pin stimulus.

## Interface
- `BITS`, 5: word width, equal to the slave shifter length; ≥2.
- `CLK_DIV`, 2: system clocks per SCLK half-period; ≥1.
- `CS_GAP`, 2: system clocks `o_cs` stays high after a transfer before the next start is accepted; ≥1.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start request; sampled only when `o_busy`=0.
- `i_tx_data`  in  BITS  word to send; captured in the cycle `i_start` is accepted.
- `o_busy`  out  1  high from the cycle after acceptance through the end of the CS gap.
- `o_done`  out  1  one-cycle pulse when `o_rx_data` is updated.
- `o_rx_data`  out  BITS  last received word; held until the next `o_done`.
- `o_cs`  out  1  slave select, active-low.
- `o_sclk`  out  1  SPI clock, idle low (CPOL=0).
- `o_mosi`  out  1  serial data out, MSB first.
- `i_miso`  in  1  serial data in; sampled on SCLK rising edges.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, FINISH, GAP. A half-period counter counts 0..CLK_DIV-1 and a bit counter counts 0..BITS-1.
- IDLE:
  - Outputs: `o_cs`=1, `o_sclk`=0, `o_mosi`=0, `o_busy`=0.
  - `i_start`=1 latches `i_tx_data` into the TX shift register, loads `o_mosi`=`i_tx_data[BITS-1]`, drives `o_cs`=0, and moves to SETUP.
- SETUP (CLK_DIV cycles, `o_sclk`=0): gives the slave MOSI setup time, then moves to HIGH.
- HIGH (CLK_DIV cycles, `o_sclk`=1):
  - On entry, the value of `i_miso` present at that edge is shifted into the RX register LSB (left shift).
- LOW (CLK_DIV cycles, `o_sclk`=0):
  - On entry, the TX register shifts left and `o_mosi` takes the next bit.
  - If that was bit BITS-1, go to FINISH instead of HIGH; `o_mosi` is don't-care during FINISH.
- FINISH: entered after the last falling edge, with `o_sclk`=0 and `o_cs`=0 held for CLK_DIV cycles. On exit:
  - `o_cs`=1, `o_mosi`=0.
  - RX register is copied to `o_rx_data`.
  - `o_done`=1 for exactly one cycle.
  - Next state is GAP.
- GAP (CS_GAP cycles, `o_busy`=1, `o_cs`=1): then IDLE.
- `i_start` while `o_busy`=1 is ignored; it is neither queued nor able to corrupt the transfer. `i_tx_data` changes after acceptance have no effect.
- Exactly BITS rising and BITS falling SCLK edges per transfer. No SCLK edge occurs while `o_cs`=1.

## Timing
- Reset, and the state after reset deasserts:
  - `o_cs`=1, `o_sclk`=0, `o_mosi`=0, `o_busy`=0, `o_done`=0, `o_rx_data`=0, FSM in IDLE, all counters 0.
- Reset mid-transfer:
  - Next edge forces the reset values and raises `o_cs` immediately.
  - No `o_done` is issued and `o_rx_data` is cleared.
- Let E0 be the edge that samples `i_start`=1 in IDLE; T = `CLK_DIV`.
  - E0+1: `o_cs`=0, `o_busy`=1, `o_mosi`=tx MSB.
  - SCLK rise for bit k (k=0..BITS-1) at E0+1+(2k+1)·T; the fall follows T cycles later.
  - Last fall at E0+1+2·BITS·T.
  - `o_cs`↑ and `o_done` pulse at E0+1+(2·BITS+1)·T.
  - `o_busy`↓ at E0+1+(2·BITS+1)·T+CS_GAP.
- Earliest next acceptance is the edge where `o_busy` is first seen low. Back-to-back transfers therefore repeat every (2·BITS+1)·T+CS_GAP+1 cycles.
- `o_mosi` only changes when `o_sclk` falls, or at CS assertion/deassertion. It is stable for T cycles before every rising edge.
- CLK_DIV=1 is legal: SCLK = `i_clk`/2, same sequence.

## Test plan
- Reset: hold `i_rst`=1 for 3 cycles with `i_start`=1 → `o_cs`=1, `o_sclk`=0, `o_busy`=0, `o_done`=0, `o_rx_data`=0, no SCLK edges.
- Loopback: defaults (BITS=5, CLK_DIV=2, CS_GAP=2), `o_mosi` wired to `i_miso`, start with `i_tx_data`=5'b10110 →
  - `o_cs`↓ at E0+1; rises at E0+3,7,11,15,19.
  - `o_done` at E0+23 with `o_rx_data`=5'b10110; `o_busy`↓ at E0+25.
- Constant MISO: `i_miso`=1, `i_tx_data`=5'b00000 → `o_mosi` stays 0, `o_rx_data`=5'b11111. Repeat with `i_miso`=0 → `o_rx_data`=5'b00000.
- Busy lockout: pulse `i_start` at E0+5 and E0+24 with different `i_tx_data` → only one transfer, one `o_done`, `o_rx_data` from the first word. A start at E0+25 is accepted.
- Reset abort: assert `i_rst` at E0+9 for one cycle → `o_cs`=1 and `o_sclk`=0 on the next edge, no `o_done`, `o_rx_data`=0. A following start with 5'b01001 in loopback completes with `o_rx_data`=5'b01001.
- Slave integration: drive `spi_exe_unit_2` (its `i_rst` tied high). Check exactly 5 SCLK rises per CS-low window, CS high for ≥CS_GAP cycles between transfers, and `o_mosi` stable at every rise.
